// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_arbiter
// Purpose  : Register-file write-port arbiter. Pipeline writeback (A) has
//            priority over a FIFO of multi-cycle unit writes (B). Defining
//            ARB_STARVE_GUARD_EN adds a starvation guard that stalls A.
// Revision : 1.0  initial release
// ============================================================================
module rf_wr_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_wr,
    input  logic [4:0]  a_rw,
    input  logic [31:0] a_busw,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rw,
    input  logic [31:0] b_busw,
    output logic        reg_fileWr,
    output logic [4:0]  Rw,
    output logic [31:0] busW,
    output logic [31:0] b_pend
);

    localparam int                c_addr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_addr_w:0] c_depth   = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0] c_cnt_one = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    logic [4:0]          r_rw_mem   [DEPTH];
    logic [31:0]         r_data_mem [DEPTH];
    logic [c_addr_w-1:0] r_wp;
    logic [c_addr_w-1:0] r_rp;
    logic [c_addr_w:0]   r_count;

    logic w_empty;
    logic w_enq;
    logic w_grant_a;
    logic w_grant_b;

    assign w_empty   = (r_count == '0);
    assign b_ready   = (r_count < c_depth);
    // Writes to r0 complete the handshake but never occupy a slot.
    assign w_enq     = b_valid && b_ready && (b_rw != 5'd0);
    assign w_grant_a = a_wr && !a_stall;
    assign w_grant_b = !w_empty && !w_grant_a;

    always_comb begin
        reg_fileWr = 1'b0;
        Rw         = 5'd0;
        busW       = 32'd0;
        if (w_grant_a) begin
            reg_fileWr = 1'b1;
            Rw         = a_rw;
            busW       = a_busw;
        end else if (w_grant_b) begin
            reg_fileWr = 1'b1;
            Rw         = r_rw_mem[r_rp];
            busW       = r_data_mem[r_rp];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_wp <= r_wp + c_ptr_one;
            if (w_grant_b)
                r_rp <= r_rp + c_ptr_one;
            case ({w_enq, w_grant_b})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rw_mem[r_wp]   <= b_rw;
            r_data_mem[r_wp] <= b_busw;
        end
    end

    always_comb begin
        b_pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_addr_w + 1)'(i) < r_count)
                b_pend[r_rw_mem[r_rp + c_addr_w'(i)]] = 1'b1;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int                  c_starve_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(STARVE_LIMIT);

    logic [c_starve_w-1:0] r_starve;
    logic                  w_force;

    assign w_force = !w_empty && (r_starve == c_starve_lim);
    assign a_stall = a_wr && w_force;

    always_ff @(posedge clk) begin
        if (rst || w_empty || w_grant_b)
            r_starve <= '0;
        else
            r_starve <= r_starve + c_starve_w'(1);
    end
`else
    logic w_unused_starve_limit;
    assign w_unused_starve_limit = (STARVE_LIMIT != 0);
    assign a_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wr_arbiter
// Purpose  : Self-checking bench for rf_wr_arbiter (either build of
//            ARB_STARVE_GUARD_EN); B writes are tracked in a scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_wr_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_wr;
    logic [4:0]  a_rw;
    logic [31:0] a_busw;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rw;
    logic [31:0] b_busw;
    logic        reg_fileWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [31:0] b_pend;

    int n_checks = 0;
    int n_errors = 0;
    int starve   = 0;
    logic [36:0] sb [$];

    rf_wr_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_wr       (a_wr),
        .a_rw       (a_rw),
        .a_busw     (a_busw),
        .a_stall    (a_stall),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rw       (b_rw),
        .b_busw     (b_busw),
        .reg_fileWr (reg_fileWr),
        .Rw         (Rw),
        .busW       (busW),
        .b_pend     (b_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic step(input logic aw, input logic [4:0] arw, input logic [31:0] ad,
                        input logic bv, input logic [4:0] brw, input logic [31:0] bd);
        logic        e_ready, e_stall, e_wr, force_b, grant_b, was_nonempty;
        logic [4:0]  e_rw;
        logic [31:0] e_d, e_pend;
        a_wr = aw; a_rw = arw; a_busw = ad;
        b_valid = bv; b_rw = brw; b_busw = bd;

        e_ready = (sb.size() < DEPTH);
        force_b = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        force_b = (sb.size() != 0) && (starve == STARVE_LIMIT);
`endif
        e_stall = aw && force_b;
        grant_b = 1'b0;
        e_wr = 1'b0; e_rw = 5'd0; e_d = 32'd0;
        if (aw && !e_stall) begin
            e_wr = 1'b1; e_rw = arw; e_d = ad;
        end else if (sb.size() != 0) begin
            e_wr = 1'b1; e_rw = sb[0][36:32]; e_d = sb[0][31:0];
            grant_b = 1'b1;
        end
        e_pend = 32'd0;
        foreach (sb[i]) e_pend[sb[i][36:32]] = 1'b1;

        @(negedge clk);
        check("b_ready",    {31'd0, b_ready},    {31'd0, e_ready});
        check("a_stall",    {31'd0, a_stall},    {31'd0, e_stall});
        check("reg_fileWr", {31'd0, reg_fileWr}, {31'd0, e_wr});
        check("Rw",         {27'd0, Rw},         {27'd0, e_rw});
        check("busW",       busW,                e_d);
        check("b_pend",     b_pend,              e_pend);

        @(posedge clk);
        was_nonempty = (sb.size() != 0);
        if (grant_b) void'(sb.pop_front());
        if (was_nonempty && !grant_b) starve++;
        else starve = 0;
        if (bv && e_ready && brw != 5'd0) sb.push_back({brw, bd});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Reset pulse with a B request offered; it must not be accepted.
    task automatic pulse_reset();
        rst = 1'b1;
        a_wr = 1'b0; b_valid = 1'b1; b_rw = 5'd3; b_busw = 32'h3333_3333;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        starve = 0;
    endtask

    initial begin
        rst = 1'b1;
        a_wr = 1'b0; a_rw = 5'd0; a_busw = 32'd0;
        b_valid = 1'b0; b_rw = 5'd0; b_busw = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        idle(1);

        // A write with empty FIFO passes straight through
        step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0);

        // Single B write: one-cycle latency, pending bit lives one cycle
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAB);
        idle(2);

        // Fill FIFO under continuous A, then drain in order
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(1 + i), 32'hB0 + i);
        step(1'b1, 5'd20, 32'h200, 1'b1, 5'd5, 32'hB4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hB4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hB4);
        idle(5);

        // B request to r0 is accepted and dropped
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        idle(2);

        // Starvation: one B entry against continuous A
        step(1'b1, 5'd6, 32'h600, 1'b1, 5'd12, 32'hC0FFEE);
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'd7, 32'h700 + i, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Reset with three entries queued discards them
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd8, 32'h800 + i, 1'b1, 5'(20 + i), 32'hE0 + i);
        pulse_reset();
        idle(3);

        // Random traffic, covers pointer wrap and simultaneous enq/deq
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom());
        idle(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, 4, requester-B FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, 7, max consecutive cycles a valid B head may lose arbitration (guard build only).
REQ-003 SHALL have clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have a_wr  input  1  pipeline WB write request (requester A, no backpressure except a_stall).
REQ-006 SHALL have a_rw  input  5  requester A destination register.
REQ-007 SHALL have a_busw  input  32  requester A write data.
REQ-008 SHALL have a_stall  output  1  requester A must hold its write this cycle.
REQ-009 SHALL have b_valid  input  1  multi-cycle unit (MDU/late load) write request.
REQ-010 SHALL have b_ready  output  1  requester B enqueue accepted when high with b_valid.
REQ-011 SHALL have b_rw  input  5  requester B destination register.
REQ-012 SHALL have b_busw  input  32  requester B write data.
REQ-013 SHALL have reg_fileWr  output  1  register-file write enable.
REQ-014 SHALL have Rw  output  5  register-file write address.
REQ-015 SHALL have busW  output  32  register-file write data.
REQ-016 SHALL have b_pend  output  32  bit r set while any queued B entry targets register r.

Function
REQ-017 SHALL buffer B requests in a DEPTH-entry FIFO; enqueue when b_valid && b_ready on posedge clk.
REQ-018 SHALL drive b_ready = (count < DEPTH) combinationally; no enqueue-while-full even if dequeueing same cycle.
REQ-019 SHALL accept but not store B requests with b_rw == 0 (handshake completes, no FIFO entry, no write).
REQ-020 SHALL drive write port combinationally: A granted -> {1,a_rw,a_busw}; else B head granted -> {1,head.rw,head.data}; else reg_fileWr=0, Rw=0, busW=0.
REQ-021 SHALL grant A whenever a_wr=1 and a_stall=0; grant B head when FIFO non-empty and A not granted.
REQ-022 SHALL dequeue the B head on posedge clk of the cycle it is granted.
REQ-023 SHALL give a B request minimum latency of one cycle: enqueued at edge N, earliest write during cycle N+1.
REQ-024 SHALL support simultaneous enqueue and dequeue (count unchanged) when not full.
REQ-025 SHALL keep FIFO pointers modulo DEPTH, count 0..DEPTH, wrap without loss or duplication.
REQ-026 SHALL compute b_pend from valid FIFO entries only (registered state, no input feed-through); cleared bit updates at the edge its last entry dequeues.
REQ-027 SHALL pass a_wr writes to r0 to the port unchanged (register file ignores r0).
REQ-028 SHALL drive a_stall=0 in the non-guard build.

Reset
REQ-029 SHALL, with rst high at posedge clk, set count=0, pointers=0, starvation counter=0; b_pend=0, b_ready=1 and reg_fileWr=0 from the next cycle.
REQ-030 SHALL discard queued entries on reset mid-operation; the B handshake in the reset cycle is not accepted; FIFO data RAM need not be cleared.

Configuration
REQ-031 SHALL, with ARB_STARVE_GUARD_EN defined, keep a counter incremented each cycle the FIFO is non-empty and its head not granted, cleared on B grant or empty.
REQ-032 SHALL, with ARB_STARVE_GUARD_EN defined and counter == STARVE_LIMIT, grant B head that cycle and assert a_stall = a_wr.
REQ-033 SHALL, without ARB_STARVE_GUARD_EN, omit the counter, use fixed A priority and tie a_stall to 0.

Verification
REQ-034 SHALL cover: a_wr=1,a_rw=5,a_busw=0x11 with FIFO empty -> same cycle reg_fileWr=1,Rw=5,busW=0x11.
REQ-035 SHALL cover: b_valid with b_rw=9,b_busw=0xAB at edge N, a_wr=0 -> cycle N+1 Rw=9,busW=0xAB, b_pend[9]=1 during N+1, 0 after.
REQ-036 SHALL cover: 4 B enqueues with a_wr held 1 -> b_ready=0 after 4th, 5th held; a_wr drop -> entries written in order, b_ready=1 after first dequeue.
REQ-037 SHALL cover: b_valid with b_rw=0 -> b_ready=1, count stays 0, no port write.
REQ-038 SHALL cover: guard build, a_wr=1 continuous, one B entry -> 7 cycles A writes, 8th cycle B written with a_stall=1; non-guard build -> B never written while a_wr=1.
REQ-039 SHALL cover: 3 entries queued, rst pulsed one cycle -> b_pend=0, count=0, no B write afterwards.
